// File: rtl/spi_dma_prefetch.sv
`default_nettype none
// spi_dma_prefetch: sequential-DWORD read prefetch FIFO between SPI DMA reads and the HyperRAM arbiter.
// Rev 1.0
module spi_dma_prefetch #(
  parameter int DEPTH = 16,
  parameter int BURST = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dma_en_i,
  input  logic [31:0] dma_addr_i,
  input  logic        dma_rd_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_rdata_rdy_o,
  output logic        dma_busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_len_o,
  input  logic        mem_ack_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [AW:0]   ISSUE_MAX = (AW+1)'(DEPTH - BURST);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BURST_C   = CW'(BURST);

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_DATA} mstate_t;
  mstate_t state, state_nxt;

  logic [31:0]   fifo [DEPTH];
  logic [AW:0]   wptr, rptr, occ;
  logic [31:0]   fetch_addr, head_addr, pend_addr;
  logic          pending, addr_valid;
  logic [CW-1:0] beat_cnt, discard_cnt, due;
  logic          empty, hit, miss, flush, issue, beat, drop, push, pop;

  // addr_valid is cleared by reset/disable so nothing is prefetched until a
  // request has pinned the stream address; head_addr is then always the
  // address of the next word to be pushed when the FIFO is empty.
  always_comb begin
    occ   = wptr - rptr;
    empty = (occ == '0);
    hit   = pending && dma_en_i && addr_valid && !empty && (head_addr == pend_addr);
    miss  = pending && dma_en_i && (!addr_valid || (head_addr != pend_addr));
    flush = miss || !dma_en_i;
    issue = (state == M_IDLE) && dma_en_i && addr_valid && !miss && (occ <= ISSUE_MAX);
    beat  = (state == M_DATA) && mem_rvalid_i;
    drop  = beat && (flush || (discard_cnt != '0));
    push  = beat && !drop;
    pop   = hit;
    due   = '0;
    case (state)
      M_REQ:   due = BURST_C;
      M_DATA:  due = beat_cnt - CW'(beat);
      default: due = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      M_IDLE:  if (issue) state_nxt = M_REQ;
      M_REQ:   if (mem_ack_i) state_nxt = M_DATA;
      M_DATA:  if (beat && (beat_cnt == CW'(1))) state_nxt = M_IDLE;
      default: state_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= M_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr[AW-1:0]] <= mem_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr            <= '0;
      rptr            <= '0;
      fetch_addr      <= '0;
      head_addr       <= '0;
      pend_addr       <= '0;
      pending         <= 1'b0;
      addr_valid      <= 1'b0;
      beat_cnt        <= '0;
      discard_cnt     <= '0;
      dma_rdata_o     <= '0;
      dma_rdata_rdy_o <= 1'b0;
      mem_req_o       <= 1'b0;
      mem_addr_o      <= '0;
      mem_len_o       <= '0;
    end else begin
      mem_len_o       <= 8'(BURST);
      dma_rdata_rdy_o <= pop;
      if (pop) dma_rdata_o <= fifo[rptr[AW-1:0]];

      if (push) wptr <= wptr + 1'b1;
      if (flush)    rptr <= wptr;
      else if (pop) rptr <= rptr + 1'b1;

      if (!dma_en_i || hit) pending <= 1'b0;
      else if (dma_rd_i && !dma_busy_o) begin
        pending   <= 1'b1;
        pend_addr <= dma_addr_i;
      end

      if (!dma_en_i) addr_valid <= 1'b0;
      else if (miss) addr_valid <= 1'b1;

      if (miss)     head_addr <= pend_addr;
      else if (pop) head_addr <= head_addr + 32'd1;

      if (miss)       fetch_addr <= pend_addr;
      else if (issue) fetch_addr <= fetch_addr + 32'(BURST);

      if (issue) begin
        mem_req_o  <= 1'b1;
        mem_addr_o <= fetch_addr;
      end else if ((state == M_REQ) && mem_ack_i) begin
        mem_req_o  <= 1'b0;
      end

      if ((state == M_REQ) && mem_ack_i) beat_cnt <= BURST_C;
      else if (beat)                     beat_cnt <= beat_cnt - CW'(1);

      if (flush)     discard_cnt <= due;
      else if (drop) discard_cnt <= discard_cnt - CW'(1);
    end
  end

  assign dma_busy_o = pending || dma_rdata_rdy_o;

  always_ff @(posedge clk) begin
    if (resetn && push) assert (occ != FULL);
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_dma_prefetch.sv
`default_nettype none
// tb_spi_dma_prefetch: directed self-checking bench with a burst-returning memory model.
// Rev 1.0
module tb_spi_dma_prefetch;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        dma_en_i = 1'b0;
  logic [31:0] dma_addr_i = '0;
  logic        dma_rd_i = 1'b0;
  logic [31:0] dma_rdata_o;
  logic        dma_rdata_rdy_o;
  logic        dma_busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_len_o;
  logic        mem_ack_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] burst_log [256];
  int          n_burst = 0;
  int          mstate = 0;
  int          dly = 0;
  int          beats = 0;
  logic [31:0] baddr = '0;

  spi_dma_prefetch #(.DEPTH(16), .BURST(8)) dut (
    .clk(clk), .resetn(resetn), .dma_en_i(dma_en_i), .dma_addr_i(dma_addr_i),
    .dma_rd_i(dma_rd_i), .dma_rdata_o(dma_rdata_o), .dma_rdata_rdy_o(dma_rdata_rdy_o),
    .dma_busy_o(dma_busy_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_len_o(mem_len_o), .mem_ack_i(mem_ack_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Memory model: ack two cycles after seeing a request, then 8 back-to-back beats.
  initial begin
    forever begin
      @(negedge clk);
      mem_ack_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (!resetn) begin
        mstate = 0;
      end else begin
        case (mstate)
          0: if (mem_req_o) begin
               if (n_burst < 256) burst_log[n_burst] = mem_addr_o;
               n_burst++;
               baddr  = mem_addr_o;
               dly    = 1;
               mstate = 1;
             end
          1: if (dly == 0) begin
               mem_ack_i = 1'b1;
               dly       = 2;
               beats     = 0;
               mstate    = 2;
             end else dly--;
          default: if (dly != 0) dly--;
             else begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = (baddr + 32'(beats)) ^ K;
               beats++;
               if (beats == 8) mstate = 0;
             end
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    dma_en_i = 1'b0;
    dma_rd_i = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [31:0] d, output int lat);
    @(negedge clk);
    dma_addr_i = a;
    dma_rd_i   = 1'b1;
    d          = '0;
    @(negedge clk);
    dma_rd_i = 1'b0;
    lat      = 1;
    while (!dma_rdata_rdy_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!dma_rdata_rdy_o) check("rd_timeout", {31'b0, dma_rdata_rdy_o}, 32'd1);
    else d = dma_rdata_o;
  endtask

  task automatic wait_mid_burst(input logic [31:0] addr, input int min_beats);
    int t = 0;
    while (!(mstate == 2 && beats >= min_beats && baddr == addr) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("burst_wait_timeout", baddr, addr);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    int base;
    int req_seen;

    // reset state, sampled while reset is still held
    repeat (2) @(negedge clk);
    check("rst_rdy",   {31'b0, dma_rdata_rdy_o}, 32'd0);
    check("rst_busy",  {31'b0, dma_busy_o}, 32'd0);
    check("rst_req",   {31'b0, mem_req_o}, 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    check("rst_rdata", dma_rdata_o, 32'd0);
    check("rst_len",   {24'b0, mem_len_o}, 32'd0);

    // sequential stream
    do_reset();
    dma_en_i = 1'b1;
    base = n_burst;
    for (int a = 32'h100; a < 32'h120; a++) begin
      do_rd(32'(a), d, lat);
      check("strm_data", d, 32'(a) ^ K);
      if (a >= 32'h104) check("strm_lat", 32'(lat), 32'd2);
    end
    for (int i = 0; i < 4; i++) check("strm_baddr", burst_log[base+i], 32'h100 + 32'(8*i));
    check("mem_len", {24'b0, mem_len_o}, 32'd8);

    // miss while burst 0x108 is delivering
    do_reset();
    dma_en_i = 1'b1;
    for (int a = 32'h100; a < 32'h103; a++) begin
      do_rd(32'(a), d, lat);
      check("miss_pre", d, 32'(a) ^ K);
    end
    wait_mid_burst(32'h108, 2);
    base = n_burst;
    do_rd(32'h200, d, lat);
    check("miss_data", d, 32'h200 ^ K);
    check("miss_baddr", burst_log[base], 32'h200);
    do_rd(32'h201, d, lat);
    check("miss_next", d, 32'h201 ^ K);

    // full: only two bursts fit until eight words are popped
    do_reset();
    dma_en_i = 1'b1;
    base = n_burst;
    do_rd(32'h0, d, lat);
    check("full_data0", d, 32'h0 ^ K);
    repeat (200) @(negedge clk);
    check("full_nburst", 32'(n_burst - base), 32'd2);
    check("full_b0", burst_log[base], 32'h0);
    check("full_b1", burst_log[base+1], 32'h8);
    for (int a = 1; a <= 6; a++) begin
      do_rd(32'(a), d, lat);
      check("full_data", d, 32'(a) ^ K);
    end
    repeat (10) @(negedge clk);
    check("full_hold", 32'(n_burst - base), 32'd2);
    do_rd(32'h7, d, lat);
    check("full_data7", d, 32'h7 ^ K);
    repeat (10) @(negedge clk);
    check("full_third", 32'(n_burst - base), 32'd3);
    check("full_b2", burst_log[base+2], 32'h10);

    // disable mid-burst, then re-enable at a new address
    do_reset();
    dma_en_i = 1'b1;
    do_rd(32'h0, d, lat);
    wait_mid_burst(32'h8, 1);
    dma_en_i = 1'b0;
    @(negedge clk);
    check("dis_busy", {31'b0, dma_busy_o}, 32'd0);
    dma_addr_i = 32'h77;
    dma_rd_i   = 1'b1;
    @(negedge clk);
    dma_rd_i = 1'b0;
    @(negedge clk);
    check("dis_rd_ignored", {31'b0, dma_busy_o}, 32'd0);
    req_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req_o) req_seen++;
    end
    check("dis_no_req", 32'(req_seen), 32'd0);
    dma_en_i = 1'b1;
    base = n_burst;
    do_rd(32'h40, d, lat);
    check("reen_baddr", burst_log[base], 32'h40);
    check("reen_data", d, 32'h40 ^ K);

    // address wrap across 2^32
    do_reset();
    dma_en_i = 1'b1;
    base = n_burst;
    for (int i = 0; i < 8; i++) begin
      do_rd(32'hFFFFFFFC + 32'(i), d, lat);
      check("wrap_data", d, (32'hFFFFFFFC + 32'(i)) ^ K);
    end
    check("wrap_b0", burst_log[base], 32'hFFFFFFFC);
    check("wrap_b1", burst_log[base+1], 32'h4);

    // reset during M_DATA
    do_reset();
    dma_en_i = 1'b1;
    do_rd(32'h300, d, lat);
    check("mrst_pre", d, 32'h300 ^ K);
    wait_mid_burst(32'h300, 1);
    resetn   = 1'b0;
    dma_en_i = 1'b0;
    @(negedge clk);
    check("mrst_req",   {31'b0, mem_req_o}, 32'd0);
    check("mrst_maddr", mem_addr_o, 32'd0);
    check("mrst_busy",  {31'b0, dma_busy_o}, 32'd0);
    check("mrst_rdy",   {31'b0, dma_rdata_rdy_o}, 32'd0);
    check("mrst_rdata", dma_rdata_o, 32'd0);
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    dma_en_i = 1'b1;
    base = n_burst;
    do_rd(32'h0, d, lat);
    check("mrst_baddr", burst_log[base], 32'h0);
    check("mrst_data", d, 32'h0 ^ K);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
